// File: rtl/fp32_mac_pkg.sv
// fp32_mac_pkg: shared types and constants for the FP32 MAC dot-product
// sequencer (state encoding, FP32 width/zero, parameter defaults).
package fp32_mac_pkg;

  localparam int          FP32_W          = 32;
  localparam logic [31:0] FP32_POS_ZERO   = 32'h0000_0000;
  localparam int          DEF_START_HOLD  = 2;
  localparam int          DEF_TIMEOUT_CYC = 1024;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT_LO = 3'd3,
    S_WAIT_HI = 3'd4,
    S_DONE    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/fp32_mac_seq_handshake.sv
// fp32_mac_seq_handshake: start/completion tracker for one MAC operation.
// Holds mac_start high for START_HOLD cycles, then waits for the MAC done
// level to drop (start accepted) and rise again (result ready).
// Optional: FP32_MAC_SEQ_TIMEOUT_EN bounds the wait to TIMEOUT_CYC cycles.
// Ports:
//   CLK_I, RST_I     clock, async active-high reset
//   go               one-cycle request to start an operation
//   mac_done_i       MAC done level
//   mac_start        registered start level to the MAC
//   done_pulse       one cycle, the new result is on the MAC result bus
//   timeout_pulse    one cycle, the wait expired (0 when feature is off)
module fp32_mac_seq_handshake
  import fp32_mac_pkg::*;
#(
  parameter int START_HOLD  = DEF_START_HOLD,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic go,
  input  logic mac_done_i,
  output logic mac_start,
  output logic done_pulse,
  output logic timeout_pulse
);

  localparam int HW = $clog2(START_HOLD + 1);

  seq_state_t      ph;
  logic [HW-1:0]   hold_cnt;
  logic            waiting;

  assign waiting    = (ph == S_WAIT_LO) || (ph == S_WAIT_HI);
  // Completion only counts after done was seen low, so a stale high level
  // left over from the previous result can never satisfy it.
  assign done_pulse = (ph == S_WAIT_HI) && mac_done_i;

`ifdef FP32_MAC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] tcnt;

  assign timeout_pulse = waiting && !done_pulse && (tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I)         tcnt <= '0;
    else if (!waiting) tcnt <= '0;
    else               tcnt <= tcnt + 1'b1;
  end
`else
  assign timeout_pulse = 1'b0;
`endif

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ph        <= S_IDLE;
      mac_start <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      case (ph)
        S_IDLE: if (go) begin
          ph        <= S_ISSUE;
          mac_start <= 1'b1;
          hold_cnt  <= '0;
        end
        S_ISSUE: begin
          if (hold_cnt == HW'(START_HOLD - 1)) begin
            ph        <= S_WAIT_LO;
            mac_start <= 1'b0;
          end else begin
            hold_cnt  <= hold_cnt + 1'b1;
          end
        end
        S_WAIT_LO: if (!mac_done_i) ph <= S_WAIT_HI;
        S_WAIT_HI: if (mac_done_i)  ph <= S_IDLE;
        default:   ph <= S_IDLE;
      endcase
      if (timeout_pulse) ph <= S_IDLE;
    end
  end

endmodule

// File: rtl/fp32_mac_sequencer.sv
// fp32_mac_sequencer: drives a multi-cycle FP32 MAC as a dot-product engine,
// acc = acc_init + sum(alpha[k]*bravo[k]) over cmd_len operand pairs.
// Optional: FP32_MAC_SEQ_TIMEOUT_EN enables the MAC completion timeout
// (result flagged with res_err_o, carrying the last good accumulator).
// Ports:
//   CLK_I, RST_I                         clock, async active-high reset
//   cmd_valid/ready, cmd_len, cmd_acc    job command
//   op_valid/ready, op_alpha, op_bravo   operand pair stream
//   mac_alpha/bravo/acc, mac_start       registered MAC inputs
//   mac_done_i, mac_result_i             MAC done level and result
//   res_valid/ready, res_data, res_err   final result
//   busy_o                               job in progress
module fp32_mac_sequencer
  import fp32_mac_pkg::*;
#(
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int START_HOLD  = DEF_START_HOLD
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic [FP32_W-1:0] cmd_acc_i,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [FP32_W-1:0] op_alpha_i,
  input  logic [FP32_W-1:0] op_bravo_i,
  output logic [FP32_W-1:0] mac_alpha_o,
  output logic [FP32_W-1:0] mac_bravo_o,
  output logic [FP32_W-1:0] mac_acc_o,
  output logic              mac_start_o,
  input  logic              mac_done_i,
  input  logic [FP32_W-1:0] mac_result_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [FP32_W-1:0] res_data_o,
  output logic              res_err_o,
  output logic              busy_o
);

  // The top FSM stays in S_ISSUE for the whole MAC operation; the tracker
  // walks its own ISSUE -> WAIT_LO -> WAIT_HI sub-phases.
  seq_state_t        state;
  logic [LEN_W-1:0]  len_rem;
  logic [FP32_W-1:0] acc;
  logic              go, hs_done, hs_timeout;

  assign cmd_ready_o = (state == S_IDLE);
  assign op_ready_o  = (state == S_FETCH);
  assign busy_o      = (state != S_IDLE);
  assign go          = (state == S_FETCH) && op_valid_i;

  fp32_mac_seq_handshake #(
    .START_HOLD  (START_HOLD),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_hs (
    .CLK_I         (CLK_I),
    .RST_I         (RST_I),
    .go            (go),
    .mac_done_i    (mac_done_i),
    .mac_start     (mac_start_o),
    .done_pulse    (hs_done),
    .timeout_pulse (hs_timeout)
  );

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state       <= S_IDLE;
      len_rem     <= '0;
      acc         <= FP32_POS_ZERO;
      mac_alpha_o <= '0;
      mac_bravo_o <= '0;
      mac_acc_o   <= '0;
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_err_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid_i) begin
          acc     <= cmd_acc_i;
          len_rem <= cmd_len_i;
          if (cmd_len_i == '0) begin
            state       <= S_DONE;
            res_valid_o <= 1'b1;
            res_data_o  <= cmd_acc_i;
          end else begin
            state       <= S_FETCH;
          end
        end
        S_FETCH: if (op_valid_i) begin
          mac_alpha_o <= op_alpha_i;
          mac_bravo_o <= op_bravo_i;
          mac_acc_o   <= acc;
          state       <= S_ISSUE;
        end
        S_ISSUE: begin
          if (hs_done) begin
            acc     <= mac_result_i;
            len_rem <= len_rem - 1'b1;
            if (len_rem == LEN_W'(1)) begin
              state       <= S_DONE;
              res_valid_o <= 1'b1;
              res_data_o  <= mac_result_i;
            end else begin
              state       <= S_FETCH;
            end
          end else if (hs_timeout) begin
            // Abandon the job; unconsumed operands stay in the stream.
            state       <= S_DONE;
            res_valid_o <= 1'b1;
            res_data_o  <= acc;
            res_err_o   <= 1'b1;
          end
        end
        S_DONE: if (res_ready_i) begin
          state       <= S_IDLE;
          res_valid_o <= 1'b0;
          res_err_o   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_mac_sequencer.sv
module tb_fp32_mac_sequencer;

  localparam int LEN_W = 16;
  localparam int TO    = 64;
  localparam int BUDG  = 2000;

  logic              CLK_I = 1'b0;
  logic              RST_I = 1'b1;
  logic              cmd_valid_i = 1'b0, cmd_ready_o;
  logic [LEN_W-1:0]  cmd_len_i = '0;
  logic [31:0]       cmd_acc_i = '0;
  logic              op_valid_i = 1'b0, op_ready_o;
  logic [31:0]       op_alpha_i = '0, op_bravo_i = '0;
  logic [31:0]       mac_alpha_o, mac_bravo_o, mac_acc_o;
  logic              mac_start_o;
  logic              mac_done_i = 1'b1;
  logic [31:0]       mac_result_i = '0;
  logic              res_valid_o, res_ready_i = 1'b0, res_err_o, busy_o;
  logic [31:0]       res_data_o;

  int n_chk = 0, n_pass = 0;

  always #5 CLK_I = ~CLK_I;

  fp32_mac_sequencer #(.LEN_W(LEN_W), .TIMEOUT_CYC(TO), .START_HOLD(2)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_len_i(cmd_len_i), .cmd_acc_i(cmd_acc_i),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .op_alpha_i(op_alpha_i), .op_bravo_i(op_bravo_i),
    .mac_alpha_o(mac_alpha_o), .mac_bravo_o(mac_bravo_o), .mac_acc_o(mac_acc_o),
    .mac_start_o(mac_start_o), .mac_done_i(mac_done_i), .mac_result_i(mac_result_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_err_o(res_err_o), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // FP32 <-> real, normal numbers only (stimulus stays on small integers)
  function automatic real fp2r(input logic [31:0] b);
    real r;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    r = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2fp(input real v);
    real         a;
    int          e;
    logic [31:0] m;
    logic [7:0]  e8;
    if (v == 0.0) return 32'h0;
    a = (v < 0.0) ? -v : v;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m  = 32'($rtoi((a - 1.0) * 8388608.0));
    e8 = 8'(e);
    return {(v < 0.0), e8, m[22:0]};
  endfunction

  // Behavioural MAC: after a start rising edge, done stays high (stale) for
  // stale_cyc cycles, drops, and rises lat_cyc cycles later with acc+a*b.
  int   stale_cyc = 2, lat_cyc = 3;
  bit   hang = 1'b0;
  int   n_start = 0;
  logic start_q = 1'b0;
  int   mph = 0, mcnt = 0;
  logic [31:0] ma = '0, mb = '0, mc = '0;

  always @(posedge CLK_I) begin
    start_q <= mac_start_o;
    if (mac_start_o && !start_q) begin
      n_start = n_start + 1;
      mph  <= 1;
      mcnt <= stale_cyc;
      ma   <= mac_alpha_o;
      mb   <= mac_bravo_o;
      mc   <= mac_acc_o;
    end else if (mph == 1) begin
      if (mcnt == 0) begin mac_done_i <= 1'b0; mph <= 2; mcnt <= lat_cyc; end
      else mcnt <= mcnt - 1;
    end else if (mph == 2) begin
      if (mcnt != 0) mcnt <= mcnt - 1;
      else if (!hang) begin
        mac_done_i   <= 1'b1;
        mac_result_i <= r2fp(fp2r(mc) + fp2r(ma) * fp2r(mb));
        mph          <= 0;
      end
    end
  end

  logic [31:0] opa [16];
  logic [31:0] opb [16];

  task automatic send_cmd(input logic [LEN_W-1:0] len, input logic [31:0] acc);
    int t = 0;
    @(negedge CLK_I);
    cmd_valid_i = 1'b1; cmd_len_i = len; cmd_acc_i = acc;
    while (!cmd_ready_o && t < BUDG) begin @(negedge CLK_I); t++; end
    if (t >= BUDG) chk("cmd_hs_bound", 0, 1);
    @(posedge CLK_I); #1 cmd_valid_i = 1'b0;
  endtask

  task automatic send_op(input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    repeat ($urandom_range(0, 2)) @(negedge CLK_I);
    @(negedge CLK_I);
    op_valid_i = 1'b1; op_alpha_i = a; op_bravo_i = b;
    while (!op_ready_o && t < BUDG) begin @(negedge CLK_I); t++; end
    if (t >= BUDG) chk("op_hs_bound", 0, 1);
    @(posedge CLK_I); #1 op_valid_i = 1'b0;
  endtask

  task automatic get_res(output logic [31:0] d, output logic e, input int hold);
    int t = 0;
    @(negedge CLK_I);
    while (!res_valid_o && t < BUDG) begin @(negedge CLK_I); t++; end
    if (t >= BUDG) chk("res_bound", 0, 1);
    d = res_data_o; e = res_err_o;
    repeat (hold) @(negedge CLK_I);
    res_ready_i = 1'b1;
    @(posedge CLK_I); #1 res_ready_i = 1'b0;
  endtask

  function automatic logic [31:0] ref_dot(input int len, input logic [31:0] acc);
    real s = fp2r(acc);
    for (int k = 0; k < len; k++) s = s + fp2r(opa[k]) * fp2r(opb[k]);
    return r2fp(s);
  endfunction

  task automatic run_job(input string tag, input int len, input logic [31:0] acc, input int hold);
    logic [31:0] d;
    logic        e;
    send_cmd(LEN_W'(len), acc);
    for (int k = 0; k < len; k++) send_op(opa[k], opb[k]);
    get_res(d, e, hold);
    chk({tag, "_data"}, d, ref_dot(len, acc));
    chk({tag, "_err"}, e, 0);
  endtask

  function automatic logic [31:0] rint(input int lo, input int hi);
    int v = lo + int'($urandom_range(0, hi - lo));
    return r2fp(real'(v));
  endfunction

  initial begin
    int n0, t;
    bit bad;
    logic [31:0] d, a0;
    logic e;

    // reset state
    repeat (3) @(negedge CLK_I);
    chk("rst_ctl", {cmd_ready_o, op_ready_o, busy_o, res_valid_o, res_err_o, mac_start_o}, 6'b100000);
    chk("rst_data", {mac_alpha_o, mac_bravo_o, mac_acc_o, res_data_o}, 128'h0);
    RST_I = 1'b0;

    // directed: 1*2 + 3*4 + 0.5*8 = 18.0
    opa[0] = 32'h3F800000; opb[0] = 32'h40000000;
    opa[1] = 32'h40400000; opb[1] = 32'h40800000;
    opa[2] = 32'h3F000000; opb[2] = 32'h41000000;
    n0 = n_start;
    run_job("dot3", 3, 32'h0, 0);
    chk("dot3_starts", n_start - n0, 3);

    // zero-length job: result straight from the command, no MAC activity
    n0 = n_start;
    send_cmd(0, 32'h40490FDB);
    t = 0;
    while (!res_valid_o && t < 2) begin @(negedge CLK_I); t++; end
    chk("len0_valid", res_valid_o, 1);
    chk("len0_data", res_data_o, 32'h40490FDB);
    chk("len0_nostart", n_start - n0, 0);
    get_res(d, e, 0);

    // stale done held high for 5 cycles after start
    stale_cyc = 5; lat_cyc = 3;
    opa[0] = rint(-9, 9); opb[0] = rint(-9, 9);
    opa[1] = rint(-9, 9); opb[1] = rint(-9, 9);
    run_job("stale", 2, rint(-20, 20), 0);
    stale_cyc = 1;

    // backpressure in DONE, second command held off
    opa[0] = 32'h40000000; opb[0] = 32'h40400000;
    send_cmd(1, 32'h3F800000);
    send_op(opa[0], opb[0]);
    t = 0;
    while (!res_valid_o && t < BUDG) begin @(negedge CLK_I); t++; end
    d = res_data_o; bad = 1'b0;
    cmd_valid_i = 1'b1; cmd_len_i = 0; cmd_acc_i = 32'h42280000;
    repeat (20) begin
      @(negedge CLK_I);
      if (res_valid_o !== 1'b1 || res_data_o !== d || cmd_ready_o !== 1'b0) bad = 1'b1;
    end
    chk("stall_stable", bad, 0);
    chk("stall_data", d, ref_dot(1, 32'h3F800000));
    res_ready_i = 1'b1;
    @(posedge CLK_I); #1 res_ready_i = 1'b0;
    @(negedge CLK_I);
    chk("stall_cmd_rdy", cmd_ready_o, 1);
    @(posedge CLK_I); #1 cmd_valid_i = 1'b0;
    get_res(d, e, 0);
    chk("stall_cmd2", d, 32'h42280000);

    // reset in WAIT_HI of pair 2 of 4
    lat_cyc = 10;
    for (int k = 0; k < 4; k++) begin opa[k] = rint(-5, 5); opb[k] = rint(-5, 5); end
    send_cmd(4, 32'h0);
    send_op(opa[0], opb[0]);
    send_op(opa[1], opb[1]);
    t = 0;
    while (mac_done_i && t < BUDG) begin @(negedge CLK_I); t++; end
    repeat (2) @(negedge CLK_I);
    #2 RST_I = 1'b1;
    #1;
    chk("rst_mid_ctl", {cmd_ready_o, op_ready_o, busy_o, res_valid_o, res_err_o, mac_start_o}, 6'b100000);
    chk("rst_mid_data", {mac_alpha_o, mac_bravo_o, mac_acc_o, res_data_o}, 128'h0);
    @(negedge CLK_I); RST_I = 1'b0;
    lat_cyc = 3;
    repeat (20) @(negedge CLK_I);
    opa[0] = 32'h40000000; opb[0] = 32'h40000000;
    send_cmd(1, 32'h3F800000);
    send_op(opa[0], opb[0]);
    get_res(d, e, 0);
    chk("post_rst", d, 32'h40A00000);

    // randomized jobs against the reference dot product
    for (int j = 0; j < 10; j++) begin
      int len = int'($urandom_range(1, 5));
      stale_cyc = int'($urandom_range(0, 4));
      lat_cyc   = int'($urandom_range(0, 5));
      for (int k = 0; k < len; k++) begin opa[k] = rint(-9, 9); opb[k] = rint(-9, 9); end
      run_job($sformatf("rnd%0d", j), len, rint(-20, 20), int'($urandom_range(0, 3)));
    end

    // MAC never completes
    hang = 1'b1; stale_cyc = 1; lat_cyc = 2;
    a0 = rint(1, 20);
    opa[0] = rint(1, 5); opb[0] = rint(1, 5);
    n0 = n_start;
    send_cmd(2, a0);
    send_op(opa[0], opb[0]);
`ifdef FP32_MAC_SEQ_TIMEOUT_EN
    get_res(d, e, 0);
    chk("to_data", d, a0);
    chk("to_err", e, 1);
    chk("to_starts", n_start - n0, 1);
    @(negedge CLK_I);
    chk("to_idle", {cmd_ready_o, busy_o, res_err_o}, 3'b100);
`else
    repeat (10000) @(negedge CLK_I);
    chk("hang_busy", busy_o, 1);
    chk("hang_novalid", res_valid_o, 0);
    chk("hang_starts", n_start - n0, 1);
    RST_I = 1'b1;
    @(negedge CLK_I); RST_I = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
